// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: sequencer states, register-zero constant and the
// base opcode map the decoder also uses.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } seq_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an instruction in ID that reads the destination of a load still in EX.
// x0 is hardwired, so a load targeting it never creates a hazard.
module load_use_detect
    import riscv_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_sequencer.sv
// Drives PC and pipeline-register enables/flushes for the 5-stage pipeline:
// load-use stalls, redirect flushes, memory-wait freezes, HALT drain and watchdog.
module pipeline_sequencer
    import riscv_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_halt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       ex_redirect,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       freeze,
    output logic       halted,
    output logic       fault,
    output logic [1:0] dbg_state
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_TIMEOUT);

    seq_state_t    state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          halted_q, halted_d;
    logic          fault_q, fault_d;
    logic          load_use;
    logic          memwait;

    assign memwait = mem_req && !mem_ready;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .load_use    (load_use)
    );

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        wait_cnt_d  = '0;
        halted_d    = halted_q;
        fault_d     = fault_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        freeze      = 1'b0;

        case (state_q)
            RUN: begin
                pc_write   = 1'b1;
                ifid_write = 1'b1;
                if (memwait) begin
                    freeze     = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end else if (ex_redirect) begin
                    // A HALT sitting in ID behind a redirect is wrong-path and dropped.
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end else if (id_halt) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_flush  = 1'b1;
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_INIT;
                end
            end
            DRAIN: begin
                idex_flush = 1'b1;
                freeze     = memwait;
                if (!memwait) begin
                    if (drain_cnt_q == '0) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DW'(1);
                    end
                end
            end
            HALTED:  freeze = 1'b1;
            FAULT:   freeze = 1'b1;
            default: freeze = 1'b1;
        endcase

        // Watchdog covers both RUN and DRAIN; a stuck memory wins over everything.
        if (((state_q == RUN) || (state_q == DRAIN)) && memwait) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
            if (wait_cnt_d == WAIT_LIMIT) begin
                state_d  = FAULT;
                fault_d  = 1'b1;
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
        end
    end

    assign halted    = halted_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

endmodule
